flit_rr_arbiter: RTL and testbench

FLIT_RR_ARBITER -- requirements
Module: flit_rr_arbiter

---
 rtl/arb_pkg.sv | 33 +++
 rtl/flit_fifo.sv | 46 ++++
 rtl/flit_rr_arbiter.sv | 146 ++++++++++++++
 tb/tb_flit_rr_arbiter.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared flit field positions, steering code and arbitration helper.
package arb_pkg;

  localparam int FLIT_W   = 10;
  localparam int PRIO_BIT = 9;
  localparam int DEST_MSB = 8;
  localparam int DEST_LSB = 6;

  localparam logic [2:0] OUT1_DEST = 3'b010;

  typedef logic [FLIT_W-1:0] flit_t;

  typedef enum logic {
    SRC_IN1 = 1'b0,
    SRC_IN2 = 1'b1
  } src_e;

  // pdiff/pwin carry the priority override; zero them for pure round-robin
  function automatic src_e rr_pick(
    input logic r1,
    input logic r2,
    input logic pdiff,
    input logic pwin,
    input src_e last
  );
    if (r1 && r2) begin
      if (pdiff) return pwin ? SRC_IN2 : SRC_IN1;
      return (last == SRC_IN2) ? SRC_IN1 : SRC_IN2;
    end
    return r2 ? SRC_IN2 : SRC_IN1;
  endfunction

endpackage

// File: rtl/flit_fifo.sv
// Synchronous flit FIFO; pointers carry one extra wrap bit for full/empty.
module flit_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         do_push;
  logic         do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rptr[AW-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/flit_rr_arbiter.sv
// Two-input, two-output flit switch with per-output round-robin.
// Define ARB_PRIO_EN to let a sole high-priority head win contention.
module flit_rr_arbiter
  import arb_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter int         FLIT_W     = arb_pkg::FLIT_W,
  parameter logic [2:0] OUT1_DEST  = arb_pkg::OUT1_DEST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] in1_data,
  input  logic              in1_valid,
  output logic              in1_ready,
  input  logic [FLIT_W-1:0] in2_data,
  input  logic              in2_valid,
  output logic              in2_ready,
  output logic [FLIT_W-1:0] out1_data,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [FLIT_W-1:0] out2_data,
  output logic              out2_valid,
  input  logic              out2_ready
);

  logic              rdy_en;
  logic [FLIT_W-1:0] head1;
  logic [FLIT_W-1:0] head2;
  logic              full1;
  logic              full2;
  logic              empty1;
  logic              empty2;
  logic              push1;
  logic              push2;
  logic              pop1;
  logic              pop2;

  // held low through reset and released on the first edge after it
  assign in1_ready = rdy_en && !full1;
  assign in2_ready = rdy_en && !full2;
  assign push1     = in1_valid && in1_ready;
  assign push2     = in2_valid && in2_ready;

  flit_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (FLIT_W)
  ) u_fifo1 (
    .clk   (clk),
    .rst   (rst),
    .push  (push1),
    .wdata (in1_data),
    .pop   (pop1),
    .rdata (head1),
    .full  (full1),
    .empty (empty1)
  );

  flit_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (FLIT_W)
  ) u_fifo2 (
    .clk   (clk),
    .rst   (rst),
    .push  (push2),
    .wdata (in2_data),
    .pop   (pop2),
    .rdata (head2),
    .full  (full2),
    .empty (empty2)
  );

  logic h1_o1;
  logic h1_o2;
  logic h2_o1;
  logic h2_o2;
  logic ld1;
  logic ld2;
  logic gnt1;
  logic gnt2;
  logic pdiff;
  logic pwin;
  src_e win1;
  src_e win2;
  src_e last1;
  src_e last2;

  assign h1_o1 = !empty1 &&
                 (head1[DEST_MSB:DEST_LSB] == OUT1_DEST);
  assign h1_o2 = !empty1 &&
                 (head1[DEST_MSB:DEST_LSB] != OUT1_DEST);
  assign h2_o1 = !empty2 &&
                 (head2[DEST_MSB:DEST_LSB] == OUT1_DEST);
  assign h2_o2 = !empty2 &&
                 (head2[DEST_MSB:DEST_LSB] != OUT1_DEST);

`ifdef ARB_PRIO_EN
  assign pdiff = head1[PRIO_BIT] ^ head2[PRIO_BIT];
  assign pwin  = head2[PRIO_BIT];
`else
  assign pdiff = 1'b0;
  assign pwin  = 1'b0;
`endif

  assign ld1  = !out1_valid || out1_ready;
  assign ld2  = !out2_valid || out2_ready;
  assign gnt1 = ld1 && (h1_o1 || h2_o1);
  assign gnt2 = ld2 && (h1_o2 || h2_o2);

  always_comb begin
    win1 = rr_pick(h1_o1, h2_o1, pdiff, pwin, last1);
    win2 = rr_pick(h1_o2, h2_o2, pdiff, pwin, last2);
    pop1 = (gnt1 && (win1 == SRC_IN1)) ||
           (gnt2 && (win2 == SRC_IN1));
    pop2 = (gnt1 && (win1 == SRC_IN2)) ||
           (gnt2 && (win2 == SRC_IN2));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_en     <= 1'b0;
      out1_valid <= 1'b0;
      out1_data  <= '0;
      out2_valid <= 1'b0;
      out2_data  <= '0;
      last1      <= SRC_IN2;
      last2      <= SRC_IN2;
    end else begin
      rdy_en <= 1'b1;
      if (ld1) begin
        out1_valid <= gnt1;
        if (gnt1) begin
          out1_data <= (win1 == SRC_IN2) ? head2 : head1;
          last1     <= win1;
        end
      end
      if (ld2) begin
        out2_valid <= gnt2;
        if (gnt2) begin
          out2_data <= (win2 == SRC_IN2) ? head2 : head1;
          last2     <= win2;
        end
      end
    end
  end

endmodule

// File: tb/tb_flit_rr_arbiter.sv
// Scenario tasks plus a queue-based scoreboard under random traffic.
module tb_flit_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] in1_data = '0;
  logic       in1_valid = 1'b0;
  logic       in1_ready;
  logic [9:0] in2_data = '0;
  logic       in2_valid = 1'b0;
  logic       in2_ready;
  logic [9:0] out1_data;
  logic       out1_valid;
  logic       out1_ready = 1'b0;
  logic [9:0] out2_data;
  logic       out2_valid;
  logic       out2_ready = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  flit_rr_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .in1_data   (in1_data),
    .in1_valid  (in1_valid),
    .in1_ready  (in1_ready),
    .in2_data   (in2_data),
    .in2_valid  (in2_valid),
    .in2_ready  (in2_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out2_data  (out2_data),
    .out2_valid (out2_valid),
    .out2_ready (out2_ready)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    in1_valid = 1'b0;
    in2_valid = 1'b0;
    in1_data  = '0;
    in2_data  = '0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    idle_inputs();
    out1_ready = 1'b0;
    out2_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset;
    logic [23:0] got;
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    got = {in1_ready, in2_ready, out1_valid, out2_valid,
           out1_data, out2_data};
    n_checks++;
    if (got !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_state got=%h want=000000", got);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({in1_ready, in2_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL ready_before_edge got=%b want=00",
               {in1_ready, in2_ready});
    end
    step();
    n_checks++;
    if ({in1_ready, in2_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL ready_after_edge got=%b want=11",
               {in1_ready, in2_ready});
    end
  endtask

  task automatic test_parallel;
    do_reset();
    out1_ready = 1'b1;
    out2_ready = 1'b1;
    in1_valid  = 1'b1;
    in1_data   = 10'b0_010_000001;
    in2_valid  = 1'b1;
    in2_data   = 10'b0_101_000010;
    step();
    idle_inputs();
    n_checks++;
    if ({out1_valid, out2_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL par_no_bypass got=%b want=00",
               {out1_valid, out2_valid});
    end
    step();
    n_checks++;
    if ({out1_valid, out2_valid} !== 2'b11) begin
      n_fail++;
      $display("FAIL par_valid got=%b want=11",
               {out1_valid, out2_valid});
    end
    n_checks++;
    if (out1_data !== 10'h081 || out2_data !== 10'h142) begin
      n_fail++;
      $display("FAIL par_data got=%h/%h want=081/142",
               out1_data, out2_data);
    end
    step();
    n_checks++;
    if ({out1_valid, out2_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL par_drained got=%b want=00",
               {out1_valid, out2_valid});
    end
  endtask

  task automatic test_round_robin;
    logic [9:0] want [8];
    logic [9:0] got [$];
    for (int i = 0; i < 4; i++) begin
      want[2*i]   = {4'b0_010, 1'b0, 5'(i)};
      want[2*i+1] = {4'b0_010, 1'b1, 5'(i)};
    end
    do_reset();
    for (int i = 0; i < 4; i++) begin
      in1_valid = 1'b1;
      in1_data  = want[2*i];
      in2_valid = 1'b1;
      in2_data  = want[2*i+1];
      step();
    end
    idle_inputs();
    out1_ready = 1'b1;
    for (int c = 0; c < 40 && got.size() < 8; c++) begin
      if (out1_valid) got.push_back(out1_data);
      step();
    end
    n_checks++;
    if (got.size() != 8) begin
      n_fail++;
      $display("FAIL rr_count got=%0d want=8", got.size());
    end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== want[i]) begin
        n_fail++;
        $display("FAIL rr_order[%0d] got=%h want=%h",
                 i, got[i], want[i]);
      end
    end
    out1_ready = 1'b0;
  endtask

  task automatic test_stall;
    logic [9:0] want [5];
    logic [9:0] got [$];
    for (int i = 0; i < 5; i++)
      want[i] = {4'b0_010, 1'b0, 5'(i + 8)};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (in1_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_fill_ready[%0d] got=%b want=1",
                 i, in1_ready);
      end
      in1_valid = 1'b1;
      in1_data  = want[i];
      step();
    end
    idle_inputs();
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (in1_ready !== 1'b0 || out1_valid !== 1'b1 ||
          out1_data !== want[0]) begin
        n_fail++;
        $display("FAIL stall_hold got=rdy%b v%b %h want=rdy0 v1 %h",
                 in1_ready, out1_valid, out1_data, want[0]);
      end
      step();
    end
    out1_ready = 1'b1;
    for (int c = 0; c < 30 && got.size() < 5; c++) begin
      if (out1_valid) got.push_back(out1_data);
      step();
    end
    n_checks++;
    if (got.size() != 5) begin
      n_fail++;
      $display("FAIL stall_count got=%0d want=5", got.size());
    end
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== want[i]) begin
        n_fail++;
        $display("FAIL stall_order[%0d] got=%h want=%h",
                 i, got[i], want[i]);
      end
    end
    out1_ready = 1'b0;
  endtask

  task automatic test_prio;
    logic [9:0] first;
    logic [9:0] second;
`ifdef ARB_PRIO_EN
    first  = 10'h281;
    second = 10'h081;
`else
    first  = 10'h081;
    second = 10'h281;
`endif
    do_reset();
    out1_ready = 1'b1;
    in1_valid  = 1'b1;
    in1_data   = 10'h081;
    in2_valid  = 1'b1;
    in2_data   = 10'h281;
    step();
    idle_inputs();
    step();
    n_checks++;
    if (out1_valid !== 1'b1 || out1_data !== first) begin
      n_fail++;
      $display("FAIL prio_first got=v%b %h want=v1 %h",
               out1_valid, out1_data, first);
    end
    step();
    n_checks++;
    if (out1_valid !== 1'b1 || out1_data !== second) begin
      n_fail++;
      $display("FAIL prio_second got=v%b %h want=v1 %h",
               out1_valid, out1_data, second);
    end
    out1_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in1_valid = 1'b1;
      in1_data  = {4'b0_010, 1'b0, 5'(i)};
      in2_valid = 1'b1;
      in2_data  = {4'b0_101, 1'b1, 5'(i)};
      step();
    end
    idle_inputs();
    n_checks++;
    if ({out1_valid, out2_valid} !== 2'b11) begin
      n_fail++;
      $display("FAIL mid_loaded got=%b want=11",
               {out1_valid, out2_valid});
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({in1_ready, in2_ready, out1_valid, out2_valid} !== 4'b0) begin
      n_fail++;
      $display("FAIL mid_async got=%b want=0000",
               {in1_ready, in2_ready, out1_valid, out2_valid});
    end
    step();
    step();
    rst = 1'b0;
    out1_ready = 1'b1;
    out2_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      n_checks++;
      if ({out1_valid, out2_valid} !== 2'b00) begin
        n_fail++;
        $display("FAIL mid_stale[%0d] got=%b want=00",
                 c, {out1_valid, out2_valid});
      end
    end
    n_checks++;
    if ({in1_ready, in2_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL mid_ready got=%b want=11",
               {in1_ready, in2_ready});
    end
  endtask

  function automatic logic [9:0] mk_flit(input logic src,
                                         input logic [4:0] seq);
    logic [2:0] d;
    d = ($urandom_range(0, 1) == 0) ? 3'b010
                                    : 3'($urandom_range(0, 7));
    return {1'($urandom_range(0, 1)), d, src, seq};
  endfunction

  function automatic int dst_of(input logic [9:0] f);
    return (f[8:6] == 3'b010) ? 0 : 1;
  endfunction

  // expq[src*2+dst] holds flits from src still owed to output dst
  logic [9:0] expq [4][$];

  task automatic check_out(input int o, input logic [9:0] d);
    int k;
    k = (d[5] ? 2 : 0) + o;
    n_checks++;
    if (expq[k].size() == 0) begin
      n_fail++;
      $display("FAIL rnd_out%0d got=%h want=nothing", o + 1, d);
    end else begin
      if (d !== expq[k][0]) begin
        n_fail++;
        $display("FAIL rnd_out%0d got=%h want=%h",
                 o + 1, d, expq[k][0]);
      end
      void'(expq[k].pop_front());
    end
  endtask

  task automatic test_random;
    logic [4:0] seq1 = '0;
    logic [4:0] seq2 = '0;
    logic       p1v = 1'b0;
    logic       p2v = 1'b0;
    logic [9:0] p1d = '0;
    logic [9:0] p2d = '0;
    do_reset();
    for (int k = 0; k < 4; k++) expq[k].delete();
    for (int c = 0; c < 1000; c++) begin
      if (p1v) begin
        n_checks++;
        if (out1_valid !== 1'b1 || out1_data !== p1d) begin
          n_fail++;
          $display("FAIL rnd_hold1 got=v%b %h want=v1 %h",
                   out1_valid, out1_data, p1d);
        end
      end
      if (p2v) begin
        n_checks++;
        if (out2_valid !== 1'b1 || out2_data !== p2d) begin
          n_fail++;
          $display("FAIL rnd_hold2 got=v%b %h want=v1 %h",
                   out2_valid, out2_data, p2d);
        end
      end
      in1_valid  = ($urandom_range(0, 2) != 0);
      in2_valid  = ($urandom_range(0, 2) != 0);
      in1_data   = mk_flit(1'b0, seq1);
      in2_data   = mk_flit(1'b1, seq2);
      out1_ready = ($urandom_range(0, 3) != 0);
      out2_ready = ($urandom_range(0, 3) != 0);
      if (out1_valid && out1_ready) check_out(0, out1_data);
      if (out2_valid && out2_ready) check_out(1, out2_data);
      if (in1_valid && in1_ready) begin
        expq[dst_of(in1_data)].push_back(in1_data);
        seq1 = seq1 + 5'd1;
      end
      if (in2_valid && in2_ready) begin
        expq[2 + dst_of(in2_data)].push_back(in2_data);
        seq2 = seq2 + 5'd1;
      end
      p1v = out1_valid && !out1_ready;
      p2v = out2_valid && !out2_ready;
      p1d = out1_data;
      p2d = out2_data;
      step();
    end
    idle_inputs();
    out1_ready = 1'b1;
    out2_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (out1_valid) check_out(0, out1_data);
      if (out2_valid) check_out(1, out2_data);
      step();
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (expq[k].size() != 0) begin
        n_fail++;
        $display("FAIL rnd_leftover[%0d] got=%0d want=0",
                 k, expq[k].size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_parallel();
    test_round_robin();
    test_stall();
    test_prio();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
